// File: rtl/icache_pkg.sv
// Shared types and helpers for the icache control block.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package icache_pkg;

  // Controller states: lookup, line refill, whole-cache invalidate.
  typedef enum logic [1:0] {
    CHECK = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2
  } icache_state_t;

  // A binary PLRU tree over WAYS leaves has WAYS-1 internal nodes.
  function automatic int plru_width(input int ways);
    return ways - 1;
  endfunction

endpackage

// File: rtl/icache_plru.sv
// Per-set tree pseudo-LRU state with combinational victim lookup.
// Latency: victim lookup is combinational; updates land on the next clk edge.
// Backpressure: none; clear takes precedence over update in the same cycle.
import icache_pkg::*;

module icache_plru #(
  parameter int WAYS = 4,
  parameter int SETS = 16,
  localparam int SW  = (SETS > 1) ? $clog2(SETS) : 1,
  localparam int WW  = $clog2(WAYS),
  localparam int PW  = plru_width(WAYS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SW-1:0]   rd_set,
  output logic [WW-1:0]   victim,
  input  logic            upd_en,
  input  logic [SW-1:0]   upd_set,
  input  logic [WAYS-1:0] upd_way,
  input  logic            clr_en,
  input  logic [SW-1:0]   clr_set
);

  // Heap-ordered tree: node n has children 2n+1 (lower ways) and 2n+2.
  logic [PW-1:0] tree_q [SETS];
  logic [PW-1:0] rd_bits;
  logic [PW-1:0] upd_bits;
  logic [WW-1:0] upd_idx;
  int            rd_node;
  int            upd_node;
  logic          rd_dir;

  // Walk the tree from the root; a 0 bit steers toward the lower-index half.
  always_comb begin
    rd_bits = tree_q[rd_set];
    victim  = '0;
    rd_node = 0;
    rd_dir  = 1'b0;
    for (int l = 0; l < WW; l++) begin
      // Node at depth l is the first node of that level plus the path prefix.
      rd_node = (1 << l) - 1 + int'(victim >> (WW - l));
      rd_dir  = 1'b0;
      for (int n = 0; n < PW; n++) begin
        if (n == rd_node) rd_dir = rd_bits[n];
      end
      victim[WW-1-l] = rd_dir;
    end
  end

  // Point every node on the accessed way's path at the opposite subtree.
  always_comb begin
    upd_idx = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (upd_way[w]) upd_idx = WW'(w);
    end
    upd_bits = tree_q[upd_set];
    upd_node = 0;
    for (int l = 0; l < WW; l++) begin
      upd_node = (1 << l) - 1 + int'(upd_idx >> (WW - l));
      for (int n = 0; n < PW; n++) begin
        if (n == upd_node) upd_bits[n] = ~upd_idx[WW-1-l];
      end
    end
  end

  // Tree storage: reset and flush clear to 0, accesses write the updated path.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
    end else if (clr_en) begin
      tree_q[clr_set] <= '0;
    end else if (upd_en) begin
      tree_q[upd_set] <= upd_bits;
    end
  end

endmodule

// File: rtl/icache_ctrl.sv
// Set-associative icache control: hit/miss, burst line fill, PLRU victim, flush.
// Latency: hit 0 cycles; miss 1 + BEATS beats + 1; flush SETS cycles.
// Backpressure: fill waits on pmem_resp per beat; fetch is held via mem_resp=0. Optional ICACHE_PERF_EN adds hit/miss counters.
import icache_pkg::*;

module icache_ctrl #(
  parameter int WAYS  = 4,
  parameter int SETS  = 16,
  parameter int BEATS = 4,
  localparam int SW   = (SETS > 1) ? $clog2(SETS) : 1,
  localparam int BW   = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int WW   = $clog2(WAYS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_read,
  output logic            mem_resp,
  input  logic [SW-1:0]   set_idx,
  input  logic [WAYS-1:0] hit_way,
  input  logic [WAYS-1:0] valid_vec,
  output logic [WAYS-1:0] way_load,
  output logic [BW-1:0]   beat_idx,
  output logic [WAYS-1:0] tag_load,
  output logic            valid_in,
  output logic            valid_clr,
  output logic [SW-1:0]   clr_set,
  output logic            pmem_read,
  input  logic            pmem_resp,
  input  logic            flush_req,
  output logic            flush_done
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]     hit_count,
  output logic [31:0]     miss_count
`endif
);

  icache_state_t   state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [SW-1:0]   fcnt_q, fcnt_d;
  logic [WAYS-1:0] victim_q, victim_d;
  logic [SW-1:0]   fill_set_q, fill_set_d;

  logic [WW-1:0]   plru_victim;
  logic [WAYS-1:0] miss_victim;
  logic            inv_found;
  logic            plru_upd_en;
  logic [SW-1:0]   plru_upd_set;
  logic [WAYS-1:0] plru_upd_way;
  logic            plru_clr_en;

  icache_plru #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_plru (
    .clk     (clk),
    .rst     (rst),
    .rd_set  (set_idx),
    .victim  (plru_victim),
    .upd_en  (plru_upd_en),
    .upd_set (plru_upd_set),
    .upd_way (plru_upd_way),
    .clr_en  (plru_clr_en),
    .clr_set (fcnt_q)
  );

  // Victim: first invalid way if any, otherwise the PLRU choice for this set.
  always_comb begin
    inv_found   = 1'b0;
    miss_victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!valid_vec[w] && !inv_found) begin
        miss_victim    = '0;
        miss_victim[w] = 1'b1;
        inv_found      = 1'b1;
      end
    end
    if (!inv_found) miss_victim = WAYS'(1) << plru_victim;
  end

  // Next state and strobes; everything is held at 0 while reset is asserted.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    fcnt_d       = fcnt_q;
    victim_d     = victim_q;
    fill_set_d   = fill_set_q;
    mem_resp     = 1'b0;
    way_load     = '0;
    beat_idx     = '0;
    tag_load     = '0;
    valid_in     = 1'b0;
    valid_clr    = 1'b0;
    clr_set      = '0;
    pmem_read    = 1'b0;
    flush_done   = 1'b0;
    plru_upd_en  = 1'b0;
    plru_upd_set = '0;
    plru_upd_way = '0;
    plru_clr_en  = 1'b0;
    if (rst) begin
      unique case (state_q)
        CHECK: begin
          // Flush wins over a pending fetch; the fetch simply waits.
          if (flush_req) begin
            state_d = FLUSH;
          end else if (mem_read) begin
            if (|hit_way) begin
              mem_resp     = 1'b1;
              plru_upd_en  = 1'b1;
              plru_upd_set = set_idx;
              plru_upd_way = hit_way;
            end else begin
              victim_d   = miss_victim;
              fill_set_d = set_idx;
              state_d    = FILL;
            end
          end
        end
        FILL: begin
          pmem_read = 1'b1;
          if (pmem_resp) begin
            way_load = victim_q;
            beat_idx = beat_q;
            if (beat_q == BW'(BEATS - 1)) begin
              // Tag and PLRU are committed with the final beat only.
              tag_load     = victim_q;
              valid_in     = 1'b1;
              plru_upd_en  = 1'b1;
              plru_upd_set = fill_set_q;
              plru_upd_way = victim_q;
              beat_d       = '0;
              state_d      = CHECK;
            end else begin
              beat_d = beat_q + BW'(1);
            end
          end
        end
        FLUSH: begin
          valid_clr   = 1'b1;
          clr_set     = fcnt_q;
          plru_clr_en = 1'b1;
          if (fcnt_q == SW'(SETS - 1)) begin
            flush_done = 1'b1;
            fcnt_d     = '0;
            state_d    = CHECK;
          end else begin
            fcnt_d = fcnt_q + SW'(1);
          end
        end
        default: state_d = CHECK;
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= CHECK;
      beat_q     <= '0;
      fcnt_q     <= '0;
      victim_q   <= '0;
      fill_set_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      fcnt_q     <= fcnt_d;
      victim_q   <= victim_d;
      fill_set_q <= fill_set_d;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count_q;
  logic [31:0] miss_count_q;
  logic        post_fill_q;

  // The response right after a refill belongs to the miss, so it is not a hit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
      post_fill_q  <= 1'b0;
    end else begin
      if (state_q == CHECK && state_d == FILL) miss_count_q <= miss_count_q + 32'd1;
      if (mem_resp) begin
        if (!post_fill_q) hit_count_q <= hit_count_q + 32'd1;
        post_fill_q <= 1'b0;
      end else if (|tag_load) begin
        post_fill_q <= 1'b1;
      end
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl with a cycle-level reference model and tag-array stand-in.
// Latency: n/a.
// Backpressure: the bench arbiter inserts configurable idle cycles between beats.
module tb_icache_ctrl;

  localparam int WAYS  = 4;
  localparam int SETS  = 16;
  localparam int BEATS = 4;
  localparam int SW    = 4;
  localparam int BW    = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            mem_read = 1'b0;
  logic            mem_resp;
  logic [SW-1:0]   set_idx = '0;
  logic [WAYS-1:0] hit_way;
  logic [WAYS-1:0] valid_vec;
  logic [WAYS-1:0] way_load;
  logic [BW-1:0]   beat_idx;
  logic [WAYS-1:0] tag_load;
  logic            valid_in;
  logic            valid_clr;
  logic [SW-1:0]   clr_set;
  logic            pmem_read;
  logic            pmem_resp = 1'b0;
  logic            flush_req = 1'b0;
  logic            flush_done;
`ifdef ICACHE_PERF_EN
  logic [31:0]     hit_count;
  logic [31:0]     miss_count;
`endif

  int checks   = 0;
  int failures = 0;

  icache_ctrl #(.WAYS(WAYS), .SETS(SETS), .BEATS(BEATS)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_resp   (mem_resp),
    .set_idx    (set_idx),
    .hit_way    (hit_way),
    .valid_vec  (valid_vec),
    .way_load   (way_load),
    .beat_idx   (beat_idx),
    .tag_load   (tag_load),
    .valid_in   (valid_in),
    .valid_clr  (valid_clr),
    .clr_set    (clr_set),
    .pmem_read  (pmem_read),
    .pmem_resp  (pmem_resp),
    .flush_req  (flush_req),
    .flush_done (flush_done)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- tag/valid array stand-in ----------------
  int              cur_tag = 0;
  int              env_tag [SETS][WAYS];
  logic [WAYS-1:0] env_val [SETS];
  logic            env_init = 1'b1;
  logic            preload_en = 1'b0;
  logic [SW-1:0]   preload_set = '0;
  int              preload_base = 0;

  always_comb begin
    valid_vec = env_val[set_idx];
    hit_way   = '0;
    for (int w = 0; w < WAYS; w++)
      hit_way[w] = env_val[set_idx][w] && (env_tag[set_idx][w] == cur_tag);
  end

  always @(posedge clk) begin
    if (env_init) begin
      for (int s = 0; s < SETS; s++) begin
        env_val[s] <= '0;
        for (int w = 0; w < WAYS; w++) env_tag[s][w] <= -1;
      end
    end else begin
      if (preload_en) begin
        env_val[preload_set] <= '1;
        for (int w = 0; w < WAYS; w++) env_tag[preload_set][w] <= preload_base + w;
      end
      for (int w = 0; w < WAYS; w++) begin
        if (tag_load[w] && valid_in) begin
          env_tag[set_idx][w] <= cur_tag;
          env_val[set_idx][w] <= 1'b1;
        end
      end
      if (valid_clr) env_val[clr_set] <= '0;
    end
  end

  // ---------------- reference model ----------------
  int              m_mode;   // 0 lookup, 1 refill, 2 invalidate
  int              m_bcnt, m_fcnt, m_victim, m_fset;
  bit              m_post;
  logic [WAYS-2:0] m_plru [SETS];
  logic [31:0]     m_hits, m_misses;

  // Descend by halving the way range; a 0 node means the victim is in the lower half.
  function automatic int f_victim(input logic [WAYS-2:0] b);
    int lo, span, node;
    lo = 0; span = WAYS; node = 0;
    while (span > 1) begin
      if (b[node] == 1'b0) node = 2 * node + 1;
      else begin lo = lo + span / 2; node = 2 * node + 2; end
      span = span / 2;
    end
    return lo;
  endfunction

  // Mark each node on the way's range path as pointing to the other half.
  function automatic logic [WAYS-2:0] f_touch(input logic [WAYS-2:0] b, input int way);
    int lo, span, node, half;
    lo = 0; span = WAYS; node = 0;
    while (span > 1) begin
      half = span / 2;
      if (way < lo + half) begin b[node] = 1'b1; node = 2 * node + 1; end
      else begin b[node] = 1'b0; lo = lo + half; node = 2 * node + 2; end
      span = half;
    end
    return b;
  endfunction

  always @(negedge clk) begin : model
    logic [WAYS-1:0] e_wl, e_tl;
    logic [BW-1:0]   e_bi;
    logic [SW-1:0]   e_cs;
    logic            e_resp, e_vi, e_vc, e_pr, e_fd;
    logic [18:0]     e_all, a_all;
    int              v;
`ifdef ICACHE_PERF_EN
    checks++;
    if (hit_count !== m_hits || miss_count !== m_misses) begin
      failures++;
      $display("FAIL perf_counters t=%0t actual=%0d/%0d required=%0d/%0d",
               $time, hit_count, miss_count, m_hits, m_misses);
    end
`endif
    e_wl = '0; e_tl = '0; e_bi = '0; e_cs = '0;
    e_resp = 1'b0; e_vi = 1'b0; e_vc = 1'b0; e_pr = 1'b0; e_fd = 1'b0;
    if (!rst) begin
      m_mode = 0; m_bcnt = 0; m_fcnt = 0; m_victim = 0; m_fset = 0; m_post = 0;
      m_hits = '0; m_misses = '0;
      for (int s = 0; s < SETS; s++) m_plru[s] = '0;
    end else begin
      case (m_mode)
        0: begin
          if (flush_req) begin
            m_mode = 2; m_fcnt = 0;
          end else if (mem_read) begin
            if (hit_way != 0) begin
              e_resp = 1'b1;
              v = 0;
              for (int w = 0; w < WAYS; w++) if (hit_way[w]) v = w;
              m_plru[set_idx] = f_touch(m_plru[set_idx], v);
              if (!m_post) m_hits = m_hits + 1;
              m_post = 0;
            end else begin
              v = -1;
              for (int w = 0; w < WAYS; w++) if (!valid_vec[w] && v < 0) v = w;
              if (v < 0) v = f_victim(m_plru[set_idx]);
              m_victim = v; m_fset = int'(set_idx); m_mode = 1;
              m_misses = m_misses + 1;
            end
          end
        end
        1: begin
          e_pr = 1'b1;
          if (pmem_resp) begin
            e_wl = WAYS'(1) << m_victim;
            e_bi = BW'(m_bcnt);
            if (m_bcnt == BEATS - 1) begin
              e_tl = WAYS'(1) << m_victim;
              e_vi = 1'b1;
              m_plru[m_fset] = f_touch(m_plru[m_fset], m_victim);
              m_mode = 0; m_bcnt = 0; m_post = 1;
            end else begin
              m_bcnt++;
            end
          end
        end
        default: begin
          e_vc = 1'b1;
          e_cs = SW'(m_fcnt);
          m_plru[m_fcnt] = '0;
          if (m_fcnt == SETS - 1) begin
            e_fd = 1'b1; m_mode = 0; m_fcnt = 0;
          end else begin
            m_fcnt++;
          end
        end
      endcase
    end
    e_all = {e_resp, e_wl, e_bi, e_tl, e_vi, e_vc, e_cs, e_pr, e_fd};
    a_all = {mem_resp, way_load, beat_idx, tag_load, valid_in, valid_clr, clr_set, pmem_read, flush_done};
    checks++;
    if (a_all !== e_all) begin
      failures++;
      $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, a_all, e_all);
    end
  end

  // ---------------- directed stimulus ----------------
  logic [WAYS-1:0] wq [$];
  int              bq [$];
  logic [WAYS-1:0] tq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic preload(input int s, input int base);
    preload_set = SW'(s); preload_base = base; preload_en = 1'b1;
    @(posedge clk); #1;
    preload_en = 1'b0;
  endtask

  // Issue one fetch and act as the arbiter; records every fill beat.
  task automatic fetch(input int s, input int t, input int gap,
                       input int flush_at, input int rst_at, output int lat);
    int given, gc;
    bit done;
    wq.delete(); bq.delete(); tq.delete();
    set_idx = SW'(s); cur_tag = t; mem_read = 1'b1;
    given = 0; gc = gap; done = 0; lat = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      lat++;
      pmem_resp = 1'b0;
      if (pmem_read) begin
        if (gc >= gap) begin
          pmem_resp = 1'b1; gc = 0;
          if (given == flush_at) flush_req = 1'b1;
          if (given == rst_at) rst = 1'b0;
          given++;
        end else begin
          gc++;
        end
      end
      #1;
      if (way_load != 0) begin
        wq.push_back(way_load); bq.push_back(int'(beat_idx)); tq.push_back(tag_load);
      end
      if (mem_resp || !rst || (flush_req && given == BEATS && !pmem_read)) done = 1;
      @(posedge clk); #1;
    end
    pmem_resp = 1'b0; mem_read = 1'b0;
    if (!rst) rst = 1'b1;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL fetch_timeout set=%0d actual=pending required=complete", s);
    end
  endtask

  task automatic wait_flush(output int n, output int last);
    bit done, seq_ok;
    done = 0; seq_ok = 1; n = 0; last = -1;
    for (int c = 0; c < 100 && !done; c++) begin
      #1;
      if (valid_clr) begin
        if (int'(clr_set) != n) seq_ok = 0;
        n++;
      end
      if (flush_done) begin done = 1; last = int'(clr_set); end
      @(posedge clk); #1;
    end
    flush_req = 1'b0;
    chk("flush_done_seen", 32'(done), 32'd1);
    chk("flush_set_order", 32'(seq_ok), 32'd1);
  endtask

  initial begin
    int lat, n, last;
    repeat (2) @(posedge clk);
    #1;
    env_init = 1'b0;
    rst = 1'b1;
    #1;
    chk("reset_outputs", 32'({mem_resp, way_load, tag_load, valid_in, valid_clr, pmem_read, flush_done}), 32'd0);

    // Cold set 3: lowest invalid way 0, beats 0..3, tag on the last beat.
    @(posedge clk); #1;
    fetch(3, 7, 0, -1, -1, lat);
    chk("cold_latency", 32'(lat), 32'd6);
    chk("cold_beats", 32'(wq.size()), 32'd4);
    if (wq.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("cold_way_load", 32'(wq[i]), 32'b0001);
        chk("cold_beat_idx", 32'(bq[i]), 32'(i));
      end
      chk("cold_tag_load_last", 32'(tq[3]), 32'b0001);
      chk("cold_tag_load_first", 32'(tq[0]), 32'd0);
    end
    fetch(3, 7, 0, -1, -1, lat);
    chk("hit_latency", 32'(lat), 32'd1);

    // Two idle cycles between beats: 2 + 4 beats + 3*2 stalls.
    fetch(9, 11, 2, -1, -1, lat);
    chk("stall_latency", 32'(lat), 32'd12);
    chk("stall_beats", 32'(wq.size()), 32'd4);
    if (wq.size() == 4) chk("stall_last_beat", 32'(bq[3]), 32'd3);

    // Full set 5 from reset PLRU. Hits 0,1,2 leave root pointing low and the
    // low node pointing at way 0; refilling way 0 then steers to way 3.
    do_reset();
    preload(5, 100);
    for (int w = 0; w < 3; w++) begin
      fetch(5, 100 + w, 0, -1, -1, lat);
      chk("plru_hit_latency", 32'(lat), 32'd1);
    end
    fetch(5, 200, 0, -1, -1, lat);
    if (wq.size() > 0) chk("plru_victim_a", 32'(wq[0]), 32'b0001);
    else chk("plru_victim_a_beats", 32'(wq.size()), 32'd4);
    fetch(5, 201, 0, -1, -1, lat);
    if (wq.size() > 0) chk("plru_victim_b", 32'(wq[0]), 32'b1000);
    else chk("plru_victim_b_beats", 32'(wq.size()), 32'd4);

    // Flush raised on beat 1: the fill finishes, then 16 set clears.
    fetch(7, 9, 0, 1, -1, lat);
    chk("flush_fill_beats", 32'(wq.size()), 32'd4);
    wait_flush(n, last);
    chk("flush_cycles", 32'(n), 32'd16);
    chk("flush_last_set", 32'(last), 32'd15);
    // Cleared PLRU sends a full-set miss to way 0 (stale tree would pick way 1).
    preload(5, 100);
    fetch(5, 300, 0, -1, -1, lat);
    if (wq.size() > 0) chk("flush_plru_cleared", 32'(wq[0]), 32'b0001);
    else chk("flush_plru_beats", 32'(wq.size()), 32'd4);

    // Flush from idle.
    flush_req = 1'b1;
    wait_flush(n, last);
    chk("idle_flush_cycles", 32'(n), 32'd16);

    // Reset on fill beat 2 abandons the fill; the retry starts at beat 0.
    fetch(12, 40, 0, -1, 2, lat);
    #1;
    chk("rst_fill_pmem_read", 32'(pmem_read), 32'd0);
    chk("rst_fill_strobes", 32'({way_load, tag_load, valid_clr, mem_resp}), 32'd0);
    @(posedge clk); #1;
    fetch(12, 40, 0, -1, -1, lat);
    chk("rst_retry_latency", 32'(lat), 32'd6);
    if (bq.size() > 0) chk("rst_retry_beat0", 32'(bq[0]), 32'd0);
    else chk("rst_retry_beats", 32'(bq.size()), 32'd4);

    // 2 misses, 3 hits.
    do_reset();
    fetch(1, 50, 0, -1, -1, lat);
    for (int i = 0; i < 3; i++) fetch(1, 50, 0, -1, -1, lat);
    fetch(2, 60, 0, -1, -1, lat);
    chk("perf_seq_miss_latency", 32'(lat), 32'd6);
`ifdef ICACHE_PERF_EN
    #1;
    chk("hit_count", hit_count, 32'd3);
    chk("miss_count", miss_count, 32'd2);
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
